// File: rtl/rw_burst_fsm.sv
// rw_burst_fsm: read/write burst sequencer.
// A one-hot FSM (IDLE/RD/WR) with a beat counter runs fixed-length bursts.
// Read/write priority in IDLE is set at build time.
// A write request that arrives during a read can optionally abort the read
// and chain it into a write burst.
// Every output comes straight from a flop, so there is no combinational path
// from sel to any output.

module rw_burst_fsm #(
  parameter int RD_LEN   = 2,
  parameter int WR_LEN   = 2,
  parameter int CNT_W    = 8,
  parameter int PRIO_WR  = 0,
  parameter int CHAIN_EN = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       sel,
  output logic [2:0]       out,
  output logic [2:0]       state_o,
  output logic             busy,
  output logic [CNT_W-1:0] beat,
  output logic             rd_done,
  output logic             wr_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RD   = 3'b010,
    S_WR   = 3'b100
  } state_e;

  // Phase codes presented on 'out'; the RD->WR chain reuses the write-beat code
  localparam logic [2:0] PH_IDLE     = 3'b000;
  localparam logic [2:0] PH_WR_START = 3'b001;
  localparam logic [2:0] PH_WR_BEAT  = 3'b010;
  localparam logic [2:0] PH_RD_START = 3'b011;
  localparam logic [2:0] PH_RD_BEAT  = 3'b100;

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LEN - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LEN - 1);
  localparam logic [CNT_W-1:0] BEAT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [2:0]       out_q;
  logic [CNT_W-1:0] beat_q;
  logic             rdDone_q;
  logic             wrDone_q;

  logic readWins;
  logic writeWins;
  logic chainReq;

  // Request arbitration in IDLE and the read-abort condition; these only feed flops
  always_comb begin
    readWins  = sel[0] && !((PRIO_WR != 0) && sel[1]);
    writeWins = sel[1] && !readWins;
    chainReq  = (CHAIN_EN != 0) && sel[1];
  end

  // Burst sequencer: state, beat counter, phase code and done pulses all registered together
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      out_q    <= PH_IDLE;
      beat_q   <= '0;
      rdDone_q <= 1'b0;
      wrDone_q <= 1'b0;
    end else begin
      rdDone_q <= 1'b0;
      wrDone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          beat_q <= '0;
          if (readWins) begin
            state_q <= S_RD;
            out_q   <= PH_RD_START;
          end else if (writeWins) begin
            state_q <= S_WR;
            out_q   <= PH_WR_START;
          end else begin
            state_q <= S_IDLE;
            out_q   <= PH_IDLE;
          end
        end
        S_RD: begin
          if (chainReq) begin
            state_q <= S_WR;
            beat_q  <= '0;
            out_q   <= PH_WR_BEAT;
          end else if (beat_q == RD_LAST) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            out_q    <= PH_IDLE;
            rdDone_q <= 1'b1;
          end else begin
            state_q <= S_RD;
            beat_q  <= beat_q + BEAT_ONE;
            out_q   <= PH_RD_BEAT;
          end
        end
        S_WR: begin
          if (beat_q == WR_LAST) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            out_q    <= PH_IDLE;
            wrDone_q <= 1'b1;
          end else begin
            state_q <= S_WR;
            beat_q  <= beat_q + BEAT_ONE;
            out_q   <= PH_WR_BEAT;
          end
        end
        default: begin
          state_q <= S_IDLE;
          beat_q  <= '0;
          out_q   <= PH_IDLE;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign state_o = state_q;
  assign busy    = (state_q != S_IDLE);
  assign beat    = beat_q;
  assign rd_done = rdDone_q;
  assign wr_done = wrDone_q;

endmodule

// File: tb/tb_rw_burst_fsm.sv
// Testbench for rw_burst_fsm.
// Three differently configured instances share one stimulus stream.
// A burst-level reference model predicts each edge's outputs into per-instance
// queues, and a negedge monitor drains the queues against the DUTs.
// Directed checks with literal values cover the documented scenarios.

module tb_rw_burst_fsm;

  localparam int N  = 3;
  localparam int CW = 8;

  localparam int RD0 = 3, WR0 = 4, PW0 = 0, CH0 = 1;
  localparam int RD1 = 3, WR1 = 4, PW1 = 1, CH1 = 0;
  localparam int RD2 = 1, WR2 = 1, PW2 = 0, CH2 = 1;

  localparam int MODE_IDLE = 0;
  localparam int MODE_RD   = 1;
  localparam int MODE_WR   = 2;

  localparam logic [2:0] RD_SEQ_OUT  [4] = '{3'b011, 3'b100, 3'b100, 3'b000};
  localparam int         RD_SEQ_BEAT [4] = '{0, 1, 2, 0};
  localparam logic       RD_SEQ_DONE [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [2:0] CH_OUT      [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
  localparam int         CH_BEAT     [4] = '{1, 2, 3, 0};
  localparam logic       CH_DONE     [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [1:0] WH_SEL      [6] = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00};
  localparam logic [2:0] WH_OUT      [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
  localparam int         WH_BEAT     [6] = '{0, 1, 2, 3, 0, 0};
  localparam logic       WH_DONE     [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  typedef struct packed {
    logic [2:0]    out;
    logic [2:0]    st;
    logic          busy;
    logic [CW-1:0] beat;
    logic          rd;
    logic          wr;
  } snap_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] sel  = 2'b11;

  logic [2:0]    outW  [N];
  logic [2:0]    stW   [N];
  logic          busyW [N];
  logic [CW-1:0] beatW [N];
  logic          rdW   [N];
  logic          wrW   [N];

  int total = 0;
  int bad   = 0;

  snap_t q0[$];
  snap_t q1[$];
  snap_t q2[$];

  int         mMode [N];
  int         mLeft [N];
  logic [2:0] mPh   [N];
  logic       mRd   [N];
  logic       mWr   [N];

  always #5 clk = ~clk;

  rw_burst_fsm #(.RD_LEN(RD0), .WR_LEN(WR0), .CNT_W(CW), .PRIO_WR(PW0), .CHAIN_EN(CH0)) dut0 (
    .clk(clk), .rstn(rstn), .sel(sel), .out(outW[0]), .state_o(stW[0]), .busy(busyW[0]),
    .beat(beatW[0]), .rd_done(rdW[0]), .wr_done(wrW[0]));

  rw_burst_fsm #(.RD_LEN(RD1), .WR_LEN(WR1), .CNT_W(CW), .PRIO_WR(PW1), .CHAIN_EN(CH1)) dut1 (
    .clk(clk), .rstn(rstn), .sel(sel), .out(outW[1]), .state_o(stW[1]), .busy(busyW[1]),
    .beat(beatW[1]), .rd_done(rdW[1]), .wr_done(wrW[1]));

  rw_burst_fsm #(.RD_LEN(RD2), .WR_LEN(WR2), .CNT_W(CW), .PRIO_WR(PW2), .CHAIN_EN(CH2)) dut2 (
    .clk(clk), .rstn(rstn), .sel(sel), .out(outW[2]), .state_o(stW[2]), .busy(busyW[2]),
    .beat(beatW[2]), .rd_done(rdW[2]), .wr_done(wrW[2]));

  function automatic int burstLen(input int k, input int mode);
    case (k)
      0:       return (mode == MODE_RD) ? RD0 : WR0;
      1:       return (mode == MODE_RD) ? RD1 : WR1;
      default: return (mode == MODE_RD) ? RD2 : WR2;
    endcase
  endfunction

  function automatic bit prioWr(input int k);
    case (k)
      0:       return PW0 != 0;
      1:       return PW1 != 0;
      default: return PW2 != 0;
    endcase
  endfunction

  function automatic bit chainEn(input int k);
    case (k)
      0:       return CH0 != 0;
      1:       return CH1 != 0;
      default: return CH2 != 0;
    endcase
  endfunction

  function automatic snap_t snapOf(input int k);
    snap_t s;
    s.out  = mPh[k];
    s.st   = (mMode[k] == MODE_RD) ? 3'b010 : (mMode[k] == MODE_WR) ? 3'b100 : 3'b001;
    s.busy = (mMode[k] != MODE_IDLE);
    s.beat = (mMode[k] == MODE_IDLE) ? '0 : CW'(burstLen(k, mMode[k]) - mLeft[k]);
    s.rd   = mRd[k];
    s.wr   = mWr[k];
    return s;
  endfunction

  task automatic resetModel(input int k);
    mMode[k] = MODE_IDLE;
    mLeft[k] = 0;
    mPh[k]   = 3'b000;
    mRd[k]   = 1'b0;
    mWr[k]   = 1'b0;
  endtask

  task automatic startBurst(input int k, input int mode);
    mMode[k] = mode;
    mLeft[k] = burstLen(k, mode);
  endtask

  // Burst-level model: a burst is a kind plus the number of cycles it still has to spend
  task automatic modelEdge(input int k, input logic [1:0] s);
    mRd[k] = 1'b0;
    mWr[k] = 1'b0;
    if (mMode[k] == MODE_IDLE) begin
      if (s[0] && !(s[1] && prioWr(k))) begin
        startBurst(k, MODE_RD);
        mPh[k] = 3'b011;
      end else if (s[1]) begin
        startBurst(k, MODE_WR);
        mPh[k] = 3'b001;
      end else begin
        mPh[k] = 3'b000;
      end
    end else if (mMode[k] == MODE_RD && chainEn(k) && s[1]) begin
      startBurst(k, MODE_WR);
      mPh[k] = 3'b010;
    end else if (mLeft[k] == 1) begin
      mRd[k]   = (mMode[k] == MODE_RD);
      mWr[k]   = (mMode[k] == MODE_WR);
      mMode[k] = MODE_IDLE;
      mPh[k]   = 3'b000;
    end else begin
      mLeft[k] = mLeft[k] - 1;
      mPh[k]   = (mMode[k] == MODE_RD) ? 3'b100 : 3'b010;
    end
  endtask

  task automatic pushExp(input int k, input snap_t s);
    case (k)
      0:       q0.push_back(s);
      1:       q1.push_back(s);
      default: q2.push_back(s);
    endcase
  endtask

  task automatic clearExp(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic popExp(input int k, output snap_t s, output bit ok);
    ok = 1'b0;
    s  = '0;
    case (k)
      0:       if (q0.size() > 0) begin s = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin s = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin s = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] s);
    rstn = r;
    sel  = s;
    @(posedge clk);
    #1;
  endtask

  // Model process: predicts every edge (and any async reset) and queues the expectation
  initial begin
    for (int k = 0; k < N; k++) resetModel(k);
    forever begin
      @(posedge clk or negedge rstn);
      for (int k = 0; k < N; k++) begin
        if (!rstn) begin
          resetModel(k);
          clearExp(k);
        end else begin
          modelEdge(k, sel);
        end
        pushExp(k, snapOf(k));
      end
    end
  end

  // Monitor process: on each falling edge pops one expectation per instance and compares
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        snap_t e;
        bit    ok;
        popExp(k, e, ok);
        if (!ok) begin
          total++;
          bad++;
          $display("[TB] FAIL sb%0d_queue: got=empty expected=one entry at t=%0t", k, $time);
        end else begin
          checkOutput($sformatf("sb%0d_out", k),  32'(outW[k]),  32'(e.out));
          checkOutput($sformatf("sb%0d_st", k),   32'(stW[k]),   32'(e.st));
          checkOutput($sformatf("sb%0d_busy", k), 32'(busyW[k]), 32'(e.busy));
          checkOutput($sformatf("sb%0d_beat", k), 32'(beatW[k]), 32'(e.beat));
          checkOutput($sformatf("sb%0d_rd", k),   32'(rdW[k]),   32'(e.rd));
          checkOutput($sformatf("sb%0d_wr", k),   32'(wrW[k]),   32'(e.wr));
        end
      end
    end
  end

  // Stimulus: directed scenarios with literal checks, then a randomized run
  initial begin
    int pulses;

    $display("[TB] start");
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b11);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("rst%0d_out", k),  32'(outW[k]),  32'h0);
      checkOutput($sformatf("rst%0d_st", k),   32'(stW[k]),   32'h1);
      checkOutput($sformatf("rst%0d_busy", k), 32'(busyW[k]), 32'h0);
      checkOutput($sformatf("rst%0d_beat", k), 32'(beatW[k]), 32'h0);
      checkOutput($sformatf("rst%0d_dones", k), 32'({rdW[k], wrW[k]}), 32'h0);
    end
    applyStimulus(1'b1, 2'b00);

    $display("[TB] single read burst");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, (i == 0) ? 2'b01 : 2'b00);
      checkOutput("rd_seq_out",  32'(outW[0]),  32'(RD_SEQ_OUT[i]));
      checkOutput("rd_seq_beat", 32'(beatW[0]), 32'(RD_SEQ_BEAT[i]));
      checkOutput("rd_seq_done", 32'(rdW[0]),   32'(RD_SEQ_DONE[i]));
      checkOutput("rd_seq_busy", 32'(busyW[0]), (i < 3) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b1, 2'b00);
    checkOutput("rd_done_width", 32'(rdW[0]), 32'h0);

    $display("[TB] priority");
    applyStimulus(1'b1, 2'b11);
    checkOutput("prio_rd_out", 32'(outW[0]), 32'h3);
    checkOutput("prio_wr_out", 32'(outW[1]), 32'h1);
    checkOutput("prio_wr_st",  32'(stW[1]),  32'h4);
    repeat (6) applyStimulus(1'b1, 2'b00);

    $display("[TB] chain");
    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b1, 2'b00);
    checkOutput("chain_pre_beat", 32'(beatW[0]), 32'h1);
    applyStimulus(1'b1, 2'b10);
    checkOutput("chain_out",   32'(outW[0]),  32'h2);
    checkOutput("chain_st",    32'(stW[0]),   32'h4);
    checkOutput("chain_beat",  32'(beatW[0]), 32'h0);
    checkOutput("chain_rd",    32'(rdW[0]),   32'h0);
    checkOutput("nochain_out", 32'(outW[1]),  32'h4);
    checkOutput("nochain_beat", 32'(beatW[1]), 32'h2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b00);
      checkOutput("chain_wr_out",  32'(outW[0]),  32'(CH_OUT[i]));
      checkOutput("chain_wr_beat", 32'(beatW[0]), 32'(CH_BEAT[i]));
      checkOutput("chain_wr_done", 32'(wrW[0]),   32'(CH_DONE[i]));
      checkOutput("chain_rd_none", 32'(rdW[0]),   32'h0);
      if (i == 0) begin
        checkOutput("nochain_rd_done", 32'(rdW[1]),  32'h1);
        checkOutput("nochain_end_out", 32'(outW[1]), 32'h0);
      end
    end
    applyStimulus(1'b1, 2'b00);

    $display("[TB] write hold");
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, WH_SEL[i]);
      checkOutput("whold_out",  32'(outW[0]),  32'(WH_OUT[i]));
      checkOutput("whold_beat", 32'(beatW[0]), 32'(WH_BEAT[i]));
      checkOutput("whold_done", 32'(wrW[0]),   32'(WH_DONE[i]));
      if (wrW[0] === 1'b1) pulses++;
    end
    checkOutput("whold_pulses", 32'(pulses), 32'h1);

    $display("[TB] reset mid write");
    applyStimulus(1'b1, 2'b10);
    applyStimulus(1'b1, 2'b00);
    checkOutput("rstwr_pre_beat", 32'(beatW[0]), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rstwr_out",  32'(outW[0]),  32'h0);
    checkOutput("rstwr_st",   32'(stW[0]),   32'h1);
    checkOutput("rstwr_beat", 32'(beatW[0]), 32'h0);
    checkOutput("rstwr_busy", 32'(busyW[0]), 32'h0);
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b1, 2'b00);
    checkOutput("rstwr_no_done", 32'(wrW[0]), 32'h0);
    applyStimulus(1'b1, 2'b01);
    checkOutput("rstwr_new_rd_out", 32'(outW[0]), 32'h3);
    checkOutput("rstwr_new_rd_st",  32'(stW[0]),  32'h2);
    repeat (4) applyStimulus(1'b1, 2'b00);

    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1, 2'($urandom_range(0, 3)));
    end

    applyStimulus(1'b1, 2'b00);
    repeat (6) applyStimulus(1'b1, 2'b00);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
